// File: rtl/adc_align_pkg.sv
// rtl/adc_align_pkg.sv - shared state, pattern and sync-word constants for adc_align_ctrl
package adc_align_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DESKEW = 3'd1;
    localparam logic [2:0] ST_SYNC   = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_DESKEW = ST_DESKEW,
        S_SYNC   = ST_SYNC,
        S_RUN    = ST_RUN,
        S_FAIL   = ST_FAIL
    } state_t;

    localparam logic [1:0] PAT_DESKEW = 2'b00;
    localparam logic [1:0] PAT_SYNC   = 2'b01;
    localparam logic [1:0] PAT_FRAME  = 2'b11;
    localparam logic [1:0] PAT_PULSE  = 2'b10;

    localparam logic [11:0] SYNC_WORD_DEF = 12'hFC0;

endpackage

// File: rtl/adc_lane_slip.sv
// rtl/adc_lane_slip.sv - per-lane sync-word matcher issuing BITSLIP pulses until locked or failed
module adc_lane_slip
    import adc_align_pkg::*;
#(
    parameter int WBITS = 12,
    parameter logic [WBITS-1:0] SYNC_WORD = WBITS'(SYNC_WORD_DEF),
    parameter int SLIP_WAIT = 8,
    parameter int MATCH_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             word_valid,
    input  logic [WBITS-1:0] word,
    output logic             bitslip,
    output logic             lock,
    output logic             fail
);

    localparam int SW = $clog2(WBITS) + 1;
    localparam int MW = $clog2(MATCH_COUNT + 1);
    localparam int WW = $clog2(SLIP_WAIT + 1);

    logic [SW-1:0] slip_cnt;
    logic [MW-1:0] match_cnt;
    logic [WW-1:0] wait_cnt;

    // A locked or failed lane is frozen until the next clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            slip_cnt  <= '0;
            match_cnt <= '0;
            wait_cnt  <= '0;
            bitslip   <= 1'b0;
            lock      <= 1'b0;
            fail      <= 1'b0;
        end else begin
            bitslip <= 1'b0;
            if (enable && word_valid && !lock && !fail) begin
                if (wait_cnt != '0) begin
                    wait_cnt <= wait_cnt - WW'(1);
                end else if (word == SYNC_WORD) begin
                    if (match_cnt == MW'(MATCH_COUNT - 1))
                        lock <= 1'b1;
                    if (match_cnt != MW'(MATCH_COUNT))
                        match_cnt <= match_cnt + MW'(1);
                end else begin
                    match_cnt <= '0;
                    bitslip   <= 1'b1;
                    slip_cnt  <= slip_cnt + SW'(1);
                    wait_cnt  <= WW'(SLIP_WAIT);
                    if (slip_cnt == SW'(WBITS - 1))
                        fail <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/adc_align_ctrl.sv
// rtl/adc_align_ctrl.sv - ADC training sequencer (deskew, sync, run); ADC_ALIGN_AUTO_RETRY_EN enables auto-retry
module adc_align_ctrl
    import adc_align_pkg::*;
#(
    parameter int NLANES = 8,
    parameter int WBITS = 12,
    parameter logic [WBITS-1:0] SYNC_WORD = WBITS'(SYNC_WORD_DEF),
    parameter int DESKEW_CYCLES = 1024,
    parameter int SLIP_WAIT = 8,
    parameter int MATCH_COUNT = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic [1:0]              RUN_PATTERN,
    input  logic                    WORD_VALID,
    input  logic [NLANES*WBITS-1:0] WORD_DATA,
    output logic [1:0]              PATTERN,
    output logic [NLANES-1:0]       BITSLIP,
    output logic [NLANES-1:0]       LANE_LOCK,
    output logic                    BUSY,
    output logic                    ALIGNED,
    output logic                    ERROR
);

    localparam int DW = (DESKEW_CYCLES > 1) ? $clog2(DESKEW_CYCLES) : 1;

    state_t            state, next_state;
    logic [DW-1:0]     deskew_cnt;
    logic              deskew_done, lane_clear, lane_enable;
    logic [NLANES-1:0] lock_vec, fail_vec;
    logic [1:0]        pattern_d;
    logic              busy_d, aligned_d, error_d;
`ifdef ADC_ALIGN_AUTO_RETRY_EN
    logic [1:0]        retry_cnt;
    logic              retry_inc;
`endif

    assign deskew_done = (state == S_DESKEW) && (deskew_cnt == DW'(DESKEW_CYCLES - 1));
    assign lane_clear  = START || deskew_done;
    assign lane_enable = (state == S_SYNC);
    assign LANE_LOCK   = lock_vec;

    always_ff @(posedge CLK) begin
        if (RST || START || state != S_DESKEW)
            deskew_cnt <= '0;
        else
            deskew_cnt <= deskew_cnt + DW'(1);
    end

`ifdef ADC_ALIGN_AUTO_RETRY_EN
    // Counts consecutive failed attempts; a successful lock starts the count over.
    always_ff @(posedge CLK) begin
        if (RST || START || next_state == S_RUN)
            retry_cnt <= 2'd0;
        else if (retry_inc)
            retry_cnt <= retry_cnt + 2'd1;
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            PATTERN <= PAT_DESKEW;
            BUSY    <= 1'b0;
            ALIGNED <= 1'b0;
            ERROR   <= 1'b0;
        end else begin
            state   <= next_state;
            PATTERN <= pattern_d;
            BUSY    <= busy_d;
            ALIGNED <= aligned_d;
            ERROR   <= error_d;
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        next_state = state;
        pattern_d  = PAT_DESKEW;
        busy_d     = 1'b0;
        aligned_d  = 1'b0;
        error_d    = 1'b0;
`ifdef ADC_ALIGN_AUTO_RETRY_EN
        retry_inc  = 1'b0;
`endif
        if (START) begin
            next_state = S_DESKEW;
        end else begin
            case (state)
                S_IDLE:   next_state = S_IDLE;
                S_DESKEW: if (deskew_done) next_state = S_SYNC;
                S_SYNC: begin
                    if (|fail_vec)
                        next_state = S_FAIL;
                    else if (&lock_vec)
                        next_state = S_RUN;
                end
                S_RUN:    next_state = S_RUN;
                S_FAIL: begin
`ifdef ADC_ALIGN_AUTO_RETRY_EN
                    if (retry_cnt != 2'd3) begin
                        next_state = S_DESKEW;
                        retry_inc  = 1'b1;
                    end
`endif
                end
                default:  next_state = S_IDLE;
            endcase
        end

        case (next_state)
            S_DESKEW: busy_d = 1'b1;
            S_SYNC: begin
                pattern_d = PAT_SYNC;
                busy_d    = 1'b1;
            end
            S_RUN: begin
                pattern_d = RUN_PATTERN;
                aligned_d = 1'b1;
            end
            S_FAIL: begin
                pattern_d = PAT_SYNC;
`ifdef ADC_ALIGN_AUTO_RETRY_EN
                error_d   = (retry_cnt == 2'd3);
`else
                error_d   = 1'b1;
`endif
            end
            default: pattern_d = PAT_DESKEW;
        endcase
    end

    for (genvar k = 0; k < NLANES; k++) begin : g_lane
        adc_lane_slip #(
            .WBITS       (WBITS),
            .SYNC_WORD   (SYNC_WORD),
            .SLIP_WAIT   (SLIP_WAIT),
            .MATCH_COUNT (MATCH_COUNT)
        ) u_lane (
            .clk        (CLK),
            .rst        (RST),
            .clear      (lane_clear),
            .enable     (lane_enable),
            .word_valid (WORD_VALID),
            .word       (WORD_DATA[k*WBITS +: WBITS]),
            .bitslip    (BITSLIP[k]),
            .lock       (lock_vec[k]),
            .fail       (fail_vec[k])
        );
    end

endmodule

// File: tb/tb_adc_align_ctrl.sv
// tb/tb_adc_align_ctrl.sv - directed self-checking bench for adc_align_ctrl
module tb_adc_align_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [1:0]  RUN_PATTERN;
    logic        WORD_VALID;
    logic [95:0] WORD_DATA;
    logic [1:0]  PATTERN;
    logic [7:0]  BITSLIP;
    logic [7:0]  LANE_LOCK;
    logic        BUSY, ALIGNED, ERROR;

    adc_align_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .RUN_PATTERN (RUN_PATTERN),
        .WORD_VALID  (WORD_VALID),
        .WORD_DATA   (WORD_DATA),
        .PATTERN     (PATTERN),
        .BITSLIP     (BITSLIP),
        .LANE_LOCK   (LANE_LOCK),
        .BUSY        (BUSY),
        .ALIGNED     (ALIGNED),
        .ERROR       (ERROR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: cumulative slip counts, double-width pulses, lane-3 pulse spacing, deskew re-entries
    int         slips [8] = '{default: 0};
    int         dbl = 0;
    int         gap_bad = 0;
    int         reentries = 0;
    int         cyc = 0;
    int         last3 = -1;
    logic [7:0] prev_bs = 8'h00;
    logic [1:0] prev_pat = 2'b00;

    always @(posedge CLK) begin
        #1;
        cyc++;
        for (int k = 0; k < 8; k++) begin
            if (BITSLIP[k]) begin
                slips[k]++;
                if (prev_bs[k]) dbl++;
            end
        end
        if (BITSLIP[3]) begin
            if (last3 >= 0 && cyc - last3 != 9) gap_bad++;
            last3 = cyc;
        end
        if (PATTERN == 2'b00 && prev_pat == 2'b01) reentries++;
        prev_bs  = BITSLIP;
        prev_pat = PATTERN;
    end

    // Lane model: lane 3 starts rotated and each BITSLIP[3] rotates it back by one bit
    int   rot3_base = 0;
    int   slip3_ref = 0;
    logic stuck0 = 1'b0;

    function automatic logic [11:0] rotl12(input logic [11:0] w, input int r);
        logic [23:0] t;
        t = {w, w} << r;
        return t[23:12];
    endfunction

    always_comb begin
        int r3;
        r3 = rot3_base - (slips[3] - slip3_ref);
        if (r3 < 0) r3 = 0;
        for (int k = 0; k < 8; k++) WORD_DATA[k*12 +: 12] = 12'hFC0;
        WORD_DATA[3*12 +: 12] = rotl12(12'hFC0, r3);
        if (stuck0) WORD_DATA[11:0] = 12'h000;
    end

    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    function automatic int other_slips();
        int s;
        s = 0;
        for (int k = 0; k < 8; k++) if (k != 3) s += slips[k];
        return s;
    endfunction

    int n, m, b0, b_other, b3, b_dbl, b_gap, b_re;
    logic others_first, err_early;

    initial begin
        RST = 1'b1; START = 1'b0; RUN_PATTERN = 2'b11; WORD_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_pattern", PATTERN, 2'b00);
        check("rst_bitslip", BITSLIP, 8'h00);
        check("rst_lock", LANE_LOCK, 8'h00);
        check("rst_busy", BUSY, 1'b0);
        check("rst_aligned", ALIGNED, 1'b0);
        check("rst_error", ERROR, 1'b0);
        RST = 1'b0; WORD_VALID = 1'b1;
        @(negedge CLK);
        check("idle_busy", BUSY, 1'b0);

        // Test 1: all lanes already framed
        b_other = other_slips(); b3 = slips[3];
        pulse_start();
        check("t1_busy", BUSY, 1'b1);
        n = 0;
        while (PATTERN == 2'b00 && BUSY && n < 3000) begin n++; @(negedge CLK); end
        check("t1_deskew_len", n, 1024);
        check("t1_pat_sync", PATTERN, 2'b01);
        m = 0;
        while (LANE_LOCK != 8'hFF && m < 100) begin m++; @(negedge CLK); end
        check("t1_lock_wait", m, 4);
        @(negedge CLK);
        check("t1_aligned", ALIGNED, 1'b1);
        check("t1_pattern_run", PATTERN, 2'b11);
        check("t1_busy_run", BUSY, 1'b0);
        check("t1_no_slips", other_slips() - b_other + slips[3] - b3, 0);
        RUN_PATTERN = 2'b10;
        @(negedge CLK);
        check("t1_live_pattern", PATTERN, 2'b10);

        // Reset while running
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("rst_run_pattern", PATTERN, 2'b00);
        check("rst_run_aligned", ALIGNED, 1'b0);
        check("rst_run_busy", BUSY, 1'b0);
        check("rst_run_lock", LANE_LOCK, 8'h00);

        // Test 2: lane 3 rotated by 5
        RUN_PATTERN = 2'b11;
        slip3_ref = slips[3]; rot3_base = 5;
        b_other = other_slips(); b3 = slips[3]; b_dbl = dbl; b_gap = gap_bad;
        others_first = 1'b0;
        pulse_start();
        n = 0;
        while (!ALIGNED && n < 3000) begin
            if (!LANE_LOCK[3] && LANE_LOCK[7:4] == 4'hF && LANE_LOCK[2:0] == 3'h7)
                others_first = 1'b1;
            n++;
            @(negedge CLK);
        end
        check("t2_aligned", ALIGNED, 1'b1);
        check("t2_lane3_slips", slips[3] - b3, 5);
        check("t2_other_slips", other_slips() - b_other, 0);
        check("t2_single_cycle", dbl - b_dbl, 0);
        check("t2_slip_spacing", gap_bad - b_gap, 0);
        check("t2_lane3_last", others_first, 1'b1);
        check("t2_pattern", PATTERN, 2'b11);

        // Test 3: lane 0 stuck, restart after two slips, then run to failure
        slip3_ref = slips[3]; rot3_base = 0; stuck0 = 1'b1;
        b0 = slips[0];
        pulse_start();
        n = 0;
        while (slips[0] - b0 < 2 && n < 3000) begin n++; @(negedge CLK); end
        check("t3_two_slips", slips[0] - b0, 2);
        check("t3_lock_before", LANE_LOCK, 8'hFE);
        pulse_start();
        check("t3_restart_pattern", PATTERN, 2'b00);
        check("t3_restart_lock", LANE_LOCK, 8'h00);
        check("t3_restart_busy", BUSY, 1'b1);
        b0 = slips[0]; b_re = reentries; err_early = 1'b0;
        n = 0;
        while (!ERROR && n < 8000) begin
            if (BUSY && ERROR) err_early = 1'b1;
            n++;
            @(negedge CLK);
        end
        check("t3_error", ERROR, 1'b1);
        check("t3_aligned", ALIGNED, 1'b0);
        check("t3_lock", LANE_LOCK, 8'hFE);
        check("t3_pattern", PATTERN, 2'b01);
        check("t3_busy", BUSY, 1'b0);
`ifdef ADC_ALIGN_AUTO_RETRY_EN
        check("t3_slips", slips[0] - b0, 48);
        check("t3_reentries", reentries - b_re, 3);
`else
        check("t3_slips", slips[0] - b0, 12);
        check("t3_reentries", reentries - b_re, 0);
`endif
        check("t3_err_early", err_early, 1'b0);
        repeat (20) @(negedge CLK);
        check("t3_error_hold", ERROR, 1'b1);
        check("t3_no_reentry", reentries - b_re,
`ifdef ADC_ALIGN_AUTO_RETRY_EN
              3
`else
              0
`endif
        );

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
